// File: rtl/rtc_pkg.sv
// Shared time-of-day types and limits for the RTC, chime and display stages.
package rtc_pkg;
  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;

  typedef struct packed {
    logic [5:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } time_t;

  function automatic logic time_legal(input time_t t);
    return (t.hour <= HOUR_MAX) && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by CLK_HZ; adv strobes on the cycle pcnt wraps while running.
module tick_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic adv
);
  localparam int W = $clog2(CLK_HZ);
  localparam logic [W-1:0] PMAX = W'(CLK_HZ - 1);

  logic [W-1:0] pcnt_q, pcnt_d;
  logic         wrap;

  assign wrap = run && (pcnt_q == PMAX);
  // a clear restarts the second, so the wrap it overlaps must not advance time
  assign adv  = wrap && !clr;

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr)       pcnt_d = '0;
    else if (wrap) pcnt_d = '0;
    else if (run)  pcnt_d = pcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end
endmodule

// File: rtl/rtc_time_base.sv
// 24-hour hh:mm:ss time base with 1 Hz tick and validated time-set loading.
module rtc_time_base
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_valid,
  input  logic [5:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic [5:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       tick_1hz,
  output logic       set_err
);
  time_t time_q, time_d, set_t;
  logic  tick_q, tick_d, err_q, err_d;
  logic  set_ok, adv;

  assign set_t  = '{hour: set_hour, min: set_min, sec: set_sec};
  assign set_ok = set_valid && time_legal(set_t);

  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
    .clk (clk),
    .rst (rst),
    .run (run),
    .clr (set_ok),
    .adv (adv)
  );

  // adv is already masked by an accepted set, so load simply takes precedence
  always_comb begin
    time_d = time_q;
    if (set_ok) begin
      time_d = set_t;
    end else if (adv) begin
      if (time_q.sec == SEC_MAX) begin
        time_d.sec = '0;
        if (time_q.min == MIN_MAX) begin
          time_d.min = '0;
          if (time_q.hour == HOUR_MAX) time_d.hour = '0;
          else                         time_d.hour = time_q.hour + 6'd1;
        end else begin
          time_d.min = time_q.min + 6'd1;
        end
      end else begin
        time_d.sec = time_q.sec + 6'd1;
      end
    end
  end

  assign tick_d = adv;
  assign err_d  = set_valid && !set_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q <= '0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      time_q <= time_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign hour     = time_q.hour;
  assign min      = time_q.min;
  assign sec      = time_q.sec;
  assign tick_1hz = tick_q;
  assign set_err  = err_q;
endmodule

// File: tb/tb_rtc_time_base.sv
// Directed bench for rtc_time_base with CLK_HZ=4 (one tick every 4 running cycles).
module tb_rtc_time_base;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b1;
  logic       set_valid = 1'b0;
  logic [5:0] set_hour = '0, set_min = '0, set_sec = '0;
  logic [5:0] hour, min, sec;
  logic       tick_1hz, set_err;

  int checks = 0;
  int failures = 0;

  rtc_time_base #(.CLK_HZ(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .set_valid(set_valid),
    .set_hour (set_hour),
    .set_min  (set_min),
    .set_sec  (set_sec),
    .hour     (hour),
    .min      (min),
    .sec      (sec),
    .tick_1hz (tick_1hz),
    .set_err  (set_err)
  );

  always #5 clk = ~clk;

  // Leaves the DUT just out of reset, 1 time unit after an edge, pcnt=0.
  task automatic apply_reset();
    rst = 1'b1; run = 1'b1; set_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive_set(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    set_valid = 1'b1; set_hour = h; set_min = m; set_sec = s;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({hour, min, sec, tick_1hz, set_err} !== 19'd0) begin
      failures++;
      $display("FAIL reset_state got %0d:%0d:%0d tick=%b err=%b want 0:0:0 0 0",
               hour, min, sec, tick_1hz, set_err);
    end
    for (int k = 1; k <= 3; k++) begin
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        checks++;
        if (tick_1hz !== (c == 4)) begin
          failures++;
          $display("FAIL tick_period sec%0d cyc%0d got tick=%b want %b", k, c, tick_1hz, c == 4);
        end
      end
      checks++;
      if ({hour, min, sec} !== {6'd0, 6'd0, 6'(k)}) begin
        failures++;
        $display("FAIL tick_count got %0d:%0d:%0d want 0:0:%0d", hour, min, sec, k);
      end
    end
  endtask

  task automatic test_rollover();
    logic [17:0] exp;
    apply_reset();
    drive_set(6'd23, 6'd59, 6'd58);
    @(posedge clk); #1;
    set_valid = 1'b0;
    checks++;
    if ({hour, min, sec, tick_1hz, set_err} !== {6'd23, 6'd59, 6'd58, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL set_load got %0d:%0d:%0d tick=%b err=%b want 23:59:58 0 0",
               hour, min, sec, tick_1hz, set_err);
    end
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      exp = (c < 4) ? {6'd23, 6'd59, 6'd58} : (c < 8) ? {6'd23, 6'd59, 6'd59} : 18'd0;
      checks++;
      if ({hour, min, sec} !== exp || tick_1hz !== (c == 4 || c == 8) || set_err !== 1'b0) begin
        failures++;
        $display("FAIL rollover cyc%0d got %0d:%0d:%0d tick=%b err=%b want %0d:%0d:%0d tick=%b err=0",
                 c, hour, min, sec, tick_1hz, set_err, exp[17:12], exp[11:6], exp[5:0],
                 c == 4 || c == 8);
      end
    end
  endtask

  task automatic test_illegal_set();
    apply_reset();
    @(posedge clk); #1;
    drive_set(6'd12, 6'd60, 6'd0);
    @(posedge clk); #1;
    set_valid = 1'b0;
    checks++;
    if (set_err !== 1'b1 || {hour, min, sec} !== 18'd0) begin
      failures++;
      $display("FAIL illegal_set got %0d:%0d:%0d err=%b want 0:0:0 err=1", hour, min, sec, set_err);
    end
    @(posedge clk); #1;
    checks++;
    if (set_err !== 1'b0 || tick_1hz !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse_width got err=%b tick=%b want err=0 tick=0", set_err, tick_1hz);
    end
    @(posedge clk); #1;
    checks++;
    if (tick_1hz !== 1'b1 || {hour, min, sec} !== {6'd0, 6'd0, 6'd1}) begin
      failures++;
      $display("FAIL illegal_phase got %0d:%0d:%0d tick=%b want 0:0:1 tick=1", hour, min, sec, tick_1hz);
    end
  endtask

  task automatic test_set_on_advance();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    drive_set(6'd10, 6'd0, 6'd0);
    @(posedge clk); #1;
    set_valid = 1'b0;
    checks++;
    if ({hour, min, sec} !== {6'd10, 6'd0, 6'd0} || tick_1hz !== 1'b0) begin
      failures++;
      $display("FAIL set_beats_adv got %0d:%0d:%0d tick=%b want 10:0:0 tick=0", hour, min, sec, tick_1hz);
    end
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (tick_1hz !== (c == 4)) begin
        failures++;
        $display("FAIL post_set_tick cyc%0d got tick=%b want %b", c, tick_1hz, c == 4);
      end
    end
    checks++;
    if ({hour, min, sec} !== {6'd10, 6'd0, 6'd1}) begin
      failures++;
      $display("FAIL post_set_time got %0d:%0d:%0d want 10:0:1", hour, min, sec);
    end
  endtask

  task automatic test_run_hold();
    apply_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    run = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (tick_1hz !== 1'b0 || {hour, min, sec} !== 18'd0) begin
        failures++;
        $display("FAIL run_hold cyc%0d got %0d:%0d:%0d tick=%b want 0:0:0 tick=0",
                 c, hour, min, sec, tick_1hz);
      end
    end
    run = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tick_1hz !== 1'b0) begin
      failures++;
      $display("FAIL resume_early got tick=%b want 0", tick_1hz);
    end
    @(posedge clk); #1;
    checks++;
    if (tick_1hz !== 1'b1 || sec !== 6'd1) begin
      failures++;
      $display("FAIL resume_tick got tick=%b sec=%0d want tick=1 sec=1", tick_1hz, sec);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive_set(6'd5, 6'd30, 6'd17);
    @(posedge clk); #1;
    set_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({hour, min, sec} !== {6'd5, 6'd30, 6'd17}) begin
      failures++;
      $display("FAIL pre_reset got %0d:%0d:%0d want 5:30:17", hour, min, sec);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({hour, min, sec, tick_1hz, set_err} !== 19'd0) begin
      failures++;
      $display("FAIL async_reset got %0d:%0d:%0d tick=%b err=%b want all zero",
               hour, min, sec, tick_1hz, set_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (tick_1hz !== (c == 4) || sec !== ((c == 4) ? 6'd1 : 6'd0)) begin
        failures++;
        $display("FAIL reset_resume cyc%0d got tick=%b sec=%0d want tick=%b sec=%0d",
                 c, tick_1hz, sec, c == 4, (c == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] vh [5] = '{6'd1, 6'd30, 6'd4, 6'd23, 6'd0};
    logic [5:0] vm [5] = '{6'd2, 6'd0, 6'd5, 6'd59, 6'd0};
    logic [5:0] vs [5] = '{6'd3, 6'd0, 6'd6, 6'd59, 6'd60};
    logic [17:0] et [5] = '{{6'd1, 6'd2, 6'd3}, {6'd1, 6'd2, 6'd3}, {6'd4, 6'd5, 6'd6},
                           {6'd23, 6'd59, 6'd59}, {6'd23, 6'd59, 6'd59}};
    logic ee [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_set(vh[i], vm[i], vs[i]);
      @(posedge clk); #1;
      checks++;
      if ({hour, min, sec} !== et[i] || set_err !== ee[i]) begin
        failures++;
        $display("FAIL back_to_back #%0d got %0d:%0d:%0d err=%b want %0d:%0d:%0d err=%b",
                 i, hour, min, sec, set_err, et[i][17:12], et[i][11:6], et[i][5:0], ee[i]);
      end
    end
    set_valid = 1'b0;
    run = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_illegal_set();
    test_set_on_advance();
    test_run_hold();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
